add_sub_serial_obfs: RTL



---
 rtl/add_sub_serial_obfs.sv | 123 ++++++++++++
 1 files changed

// File: rtl/add_sub_serial_obfs.sv
// Key-locked digit-serial adder/subtractor. Operands are held XOR-scrambled and
// unscrambled one digit at a time at the ALU; a wrong key runs a decoy state chain.
module add_sub_serial_obfs #(
  parameter int               WIDTH   = 16,
  parameter int               DIGIT   = 1,
  parameter int               KEY_W   = 8,
  parameter logic [KEY_W-1:0] KEY     = 8'hA5,
  parameter logic [WIDTH-1:0] A_MASK  = 16'h0032,
  parameter logic [WIDTH-1:0] B_MASK  = 16'hD5C5,
  parameter int               N_DECOY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [KEY_W-1:0] key,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int SW    = $clog2(N_DECOY + 3);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NDIG - 1);

  // Decoy states occupy the codes DECOY_0 .. DECOY_0+N_DECOY-1.
  typedef enum logic [SW-1:0] {IDLE, ADD, DONE, DECOY_0} state_t;
  localparam state_t DECOY_LAST = state_t'(N_DECOY + 2);

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             sub_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] out_reg;
  logic             cout_reg;
  logic             ovf_reg;

  logic [DIGIT-1:0] a_mask_dig [NDIG];
  logic [DIGIT-1:0] b_mask_dig [NDIG];

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_mask
      assign a_mask_dig[gi] = A_MASK[gi*DIGIT +: DIGIT];
      assign b_mask_dig[gi] = B_MASK[gi*DIGIT +: DIGIT];
    end
  endgenerate

  // Digit ALU: unscramble the low digit, invert b for subtraction, add with carry.
  logic [DIGIT-1:0] ad;
  logic [DIGIT-1:0] bd;
  logic [DIGIT-1:0] s;
  logic             c;

  always_comb begin
    ad     = a_reg[DIGIT-1:0] ^ a_mask_dig[count_reg];
    bd     = b_reg[DIGIT-1:0] ^ b_mask_dig[count_reg] ^ {DIGIT{sub_reg}};
    {c, s} = {1'b0, ad} + {1'b0, bd} + {{DIGIT{1'b0}}, carry_reg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      carry_reg <= 1'b0;
      count_reg <= '0;
      out_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg   <= a ^ A_MASK;
            b_reg   <= b ^ B_MASK;
            sub_reg <= sub;
            if (key == KEY) begin
              carry_reg <= sub;
              count_reg <= '0;
              out_reg   <= '0;
              cout_reg  <= 1'b0;
              ovf_reg   <= 1'b0;
              state_reg <= ADD;
            end else begin
              state_reg <= DECOY_0;
            end
          end
        end
        ADD: begin
          out_reg   <= {s, out_reg[WIDTH-1:DIGIT]};
          a_reg     <= a_reg >> DIGIT;
          b_reg     <= b_reg >> DIGIT;
          carry_reg <= c;
          count_reg <= count_reg + 1'b1;
          if (count_reg == LAST_DIGIT) begin
            cout_reg  <= c;
            ovf_reg   <= (ad[DIGIT-1] == bd[DIGIT-1]) && (s[DIGIT-1] != ad[DIGIT-1]);
            state_reg <= DONE;
          end
        end
        DONE: state_reg <= IDLE;
        // Decoy chain; unused codes also walk forward and wrap back to IDLE.
        default: state_reg <= (state_reg == DECOY_LAST) ? IDLE : state_t'(state_reg + 1'b1);
      endcase
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);
  assign out  = out_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule
